fft_peak_tracker: RTL
=====================

# fft_peak_tracker

Parametrised spectral peak detector for the tuner's FFT output stream. It computes a Manhattan magnitude per bin and searches a programmable bin window for the largest magnitude above a threshold. Once per frame it reports the peak bin, its magnitude, a found flag and a framing-error flag. It sits between the streaming FFT core and the pitch/note-lookup logic.

## Interface
- `DATA_W`, 32: signed width of each real/imag sample.
- `FFT_LEN`, 4096: expected bins per frame. Must be ≤ 2^`BIN_W`.
- `BIN_W`, 13: bin index width.
- `clk` in 1: single clock; every register is on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `sourceValid` in 1: input beat valid. `sop` and `eop` are sampled only when it is high.
- `sop` in 1: first bin of a frame.
- `eop` in 1: last bin of a frame.
- `real_sig` in `DATA_W`: signed real part.
- `img_sig` in `DATA_W`: signed imaginary part.
- `min_bin` in `BIN_W`: lowest bin searched, inclusive. Latched on each accepted `sop`.
- `max_bin` in `BIN_W`: highest bin searched, inclusive. Latched on each accepted `sop`.
- `threshold` in `DATA_W+1`: a bin qualifies only if its magnitude is strictly greater than this. Latched on each accepted `sop`.
- `peak_valid` out 1: one-cycle pulse when a report is presented.
- `peak_found` out 1: at least one bin qualified in the reported frame.
- `peak_bin` out `BIN_W`: index of the winning bin.
- `peak_mag` out `DATA_W+1`: magnitude of the winning bin.
- `frame_err` out 1: one-cycle pulse on a framing violation.
- `mag_left` out `DATA_W+1`: magnitude of bin `peak_bin`−1. Present only with `PEAK_NEIGHBOR_EN`.
- `mag_right` out `DATA_W+1`: magnitude of bin `peak_bin`+1. Present only with `PEAK_NEIGHBOR_EN`.

## Operation
- **Stage 1 (magnitude):**
  - |x| of each component is computed unsigned in `DATA_W` bits; −2^(DATA_W−1) maps exactly to 2^(DATA_W−1), with no overflow.
  - mag = |re| + |im|, `DATA_W+1` bits, never saturates.
  - mag is registered together with valid, sop and eop.
- **Bin counter:** an accepted `sop` loads 0; every other accepted beat increments. In IDLE the counter holds.
- **FSM IDLE:**
  - Accepted `sop` → SCAN. The window and threshold are latched and the best-so-far is cleared (mag 0, bin 0, found 0).
  - Accepted beats without `sop` are ignored.
  - Accepted `eop` without `sop` pulses `frame_err` and produces no report.
- **FSM SCAN, per accepted beat:**
  - The bin is a candidate if min_bin ≤ bin ≤ max_bin, mag > threshold, and (found == 0 or mag > best).
  - A candidate replaces the best. Ties keep the lower bin.
  - Accepted `eop` → REPORT.
- **Restart:** an accepted `sop` while in SCAN discards the partial frame, pulses `frame_err` and restarts SCAN from bin 0.
- **FSM REPORT:**
  - Outputs update and `peak_valid` pulses.
  - `frame_err` also pulses if the `eop` bin ≠ `FFT_LEN`−1.
  - Then → IDLE.
- **Single-beat frame:** `sop` and `eop` on the same beat is a one-bin frame. The bin is evaluated, then REPORT follows; `frame_err` pulses unless `FFT_LEN` == 1.
- **No qualifying bin:** `peak_found`=0, `peak_bin`=0, `peak_mag`=0.
- **Window edge cases:**
  - If min_bin > max_bin, no bin qualifies.
  - Bins ≥ `FFT_LEN` are still evaluated against the window.
- **Output hold:** report outputs hold their value until the next report.

## Timing
- Reset values: all outputs 0, FSM in IDLE, counter 0, best cleared.
- Latency: the beat accepted with `eop` at edge N produces `peak_valid` high in the cycle after edge N+2 (stage 1, then compare, then report register).
- Gaps: `sourceValid` gaps of any length inside a frame are tolerated. State holds and no beats are lost.
- Back-to-back frames: `sop` is accepted in the cycle right after `eop` with no bubble.
- Reset mid-frame: asynchronous clear of everything, including stage 1. No report is produced for the interrupted frame.
- No backpressure: the block always accepts.

## Configuration
- **`PEAK_NEIGHBOR_EN` defined:**
  - A previous-beat magnitude register is kept.
  - On a new best, `mag_left` is captured from the previous beat within the same frame, or 0 if the best is bin 0.
  - A pending flag captures the next accepted beat's mag as `mag_right`, regardless of the window.
  - If `eop` is the best bin, `mag_right`=0.
  - Both values are reported alongside `peak_bin`; reset value is 0.
- **`PEAK_NEIGHBOR_EN` not defined:** the ports, registers and neighbour logic are absent. All other behaviour is identical.

## Test plan
- **Basic frame:** `FFT_LEN`=16, window 0..15, threshold 0, re=10·bin except bin 5 = −500 → `peak_bin`=5, `peak_mag`=500, `peak_found`=1, no `frame_err`, `peak_valid` 3 cycles after `eop`.
- **Window and tie:** window 4..9, bins 2 and 11 = 1000, bins 6 and 8 = 300 → `peak_bin`=6 (tie keeps the lower bin), `peak_mag`=300.
- **Threshold miss:** all magnitudes ≤ 50, threshold 50 → `peak_found`=0, `peak_bin`=0, `peak_mag`=0, `peak_valid`=1.
- **Framing errors:**
  - `sop` at bin 7 of a frame, then a full frame → one `frame_err` pulse, then a correct report for the second frame.
  - `eop` at bin 9 of 16 → report plus `frame_err`.
- **Extremes and gaps:** re=img=−2^31 at bin 3 → `peak_mag`=2^32. Random `sourceValid` gaps give the same result as the gap-free run.
- **Neighbours (macro on):** bins 4, 5, 6 = 80, 200, 120 → `mag_left`=80, `mag_right`=120. Peak on the last bin → `mag_right`=0. Asserting reset mid-frame clears all outputs.

Source files
------------

// File: rtl/fft_peak_tracker.sv
// fft_peak_tracker: finds the largest Manhattan-magnitude bin in a bin window of each FFT frame.
// Pipeline: stage 1 registers |re|+|im|; stage 2 holds the bin counter and the best-so-far
// search; the report registers drive the outputs and hold their values until the next report.
// Build option: define PEAK_NEIGHBOR_EN to also report the magnitudes of the bins on either
// side of the peak (mag_left / mag_right).
module fft_peak_tracker #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned FFT_LEN = 4096,
  parameter int unsigned BIN_W   = 13
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sourceValid,
  input  logic              sop,
  input  logic              eop,
  input  logic [DATA_W-1:0] real_sig,
  input  logic [DATA_W-1:0] img_sig,
  input  logic [BIN_W-1:0]  min_bin,
  input  logic [BIN_W-1:0]  max_bin,
  input  logic [DATA_W:0]   threshold,
  output logic              peak_valid,
  output logic              peak_found,
  output logic [BIN_W-1:0]  peak_bin,
  output logic [DATA_W:0]   peak_mag,
  output logic              frame_err
`ifdef PEAK_NEIGHBOR_EN
  ,
  output logic [DATA_W:0]   mag_left,
  output logic [DATA_W:0]   mag_right
`endif
);

  localparam logic [BIN_W-1:0] LastBin = BIN_W'(FFT_LEN - 1);

  typedef enum logic [1:0] {StIdle, StScan, StReport} state_e;

  // Stage 1: magnitude pipeline
  logic [DATA_W-1:0] abs_re, abs_im;
  logic [DATA_W:0]   mag_in;
  logic              s1_valid_q, s1_sop_q, s1_eop_q;
  logic [DATA_W:0]   s1_mag_q;

  // Window and threshold, latched on the input side with each accepted sop
  logic [BIN_W-1:0]  win_min_q, win_max_q;
  logic [DATA_W:0]   win_thr_q;

  // Stage 2: search state
  state_e            state_q;
  logic [BIN_W-1:0]  cnt_q;         // index of the next beat within the frame
  logic              best_found_q;
  logic [BIN_W-1:0]  best_bin_q;
  logic [DATA_W:0]   best_mag_q;
  logic              eop_err_q;     // eop landed on a bin other than the last one

  // Report registers
  logic              peak_valid_q, peak_found_q, frame_err_q;
  logic [BIN_W-1:0]  peak_bin_q;
  logic [DATA_W:0]   peak_mag_q;

`ifdef PEAK_NEIGHBOR_EN
  logic [DATA_W:0]   prev_mag_q;
  logic [DATA_W:0]   best_left_q, best_right_q;
  logic              right_pend_q;  // next in-frame beat supplies the right neighbour
  logic [DATA_W:0]   mag_left_q, mag_right_q;
  logic [DATA_W:0]   left_val;
`endif

  // Stage-2 decode signals
  logic [BIN_W-1:0]  bin_cur;
  logic              in_frame;
  logic              base_found;
  logic [DATA_W:0]   base_mag;
  logic              in_win;
  logic              cand;
  logic              eop_bad;

  // Absolute values fit unsigned in DATA_W bits; the most negative input maps to 2^(DATA_W-1)
  always_comb begin
    abs_re = real_sig[DATA_W-1] ? (~real_sig + DATA_W'(1)) : real_sig;
    abs_im = img_sig[DATA_W-1]  ? (~img_sig  + DATA_W'(1)) : img_sig;
    mag_in = {1'b0, abs_re} + {1'b0, abs_im};
  end

  // Stage 1 registers plus window/threshold capture on accepted sop
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_sop_q   <= 1'b0;
      s1_eop_q   <= 1'b0;
      s1_mag_q   <= '0;
      win_min_q  <= '0;
      win_max_q  <= '0;
      win_thr_q  <= '0;
    end else begin
      s1_valid_q <= sourceValid;
      s1_sop_q   <= sourceValid & sop;
      s1_eop_q   <= sourceValid & eop;
      if (sourceValid) begin
        s1_mag_q <= mag_in;
      end
      if (sourceValid && sop) begin
        win_min_q <= min_bin;
        win_max_q <= max_bin;
        win_thr_q <= threshold;
      end
    end
  end

  // Candidate evaluation for the beat leaving stage 1; a sop beat compares against a cleared best
  always_comb begin
    bin_cur    = s1_sop_q ? '0 : cnt_q;
    in_frame   = s1_valid_q && (s1_sop_q || (state_q == StScan));
    base_found = s1_sop_q ? 1'b0 : best_found_q;
    base_mag   = s1_sop_q ? '0 : best_mag_q;
    in_win     = (bin_cur >= win_min_q) && (bin_cur <= win_max_q);
    // Strict greater-than against the best keeps the lower bin on ties
    cand       = in_frame && in_win && (s1_mag_q > win_thr_q) &&
                 (!base_found || (s1_mag_q > base_mag));
    eop_bad    = (bin_cur != LastBin);
`ifdef PEAK_NEIGHBOR_EN
    // Bin 0 has no left neighbour; otherwise the previous beat belongs to this frame
    left_val   = (bin_cur == '0) ? '0 : prev_mag_q;
`endif
  end

  // Search FSM, bin counter, best-so-far tracking and registered report outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      best_found_q <= 1'b0;
      best_bin_q   <= '0;
      best_mag_q   <= '0;
      eop_err_q    <= 1'b0;
      peak_valid_q <= 1'b0;
      peak_found_q <= 1'b0;
      peak_bin_q   <= '0;
      peak_mag_q   <= '0;
      frame_err_q  <= 1'b0;
`ifdef PEAK_NEIGHBOR_EN
      prev_mag_q   <= '0;
      best_left_q  <= '0;
      best_right_q <= '0;
      right_pend_q <= 1'b0;
      mag_left_q   <= '0;
      mag_right_q  <= '0;
`endif
    end else begin
      peak_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;

      // Present the finished frame; a sop arriving this same cycle overrides the Idle move below
      if (state_q == StReport) begin
        peak_valid_q <= 1'b1;
        peak_found_q <= best_found_q;
        peak_bin_q   <= best_bin_q;
        peak_mag_q   <= best_mag_q;
        if (eop_err_q) begin
          frame_err_q <= 1'b1;
        end
`ifdef PEAK_NEIGHBOR_EN
        mag_left_q   <= best_left_q;
        mag_right_q  <= best_right_q;
`endif
        state_q      <= StIdle;
      end

      if (in_frame) begin
        // A sop while scanning abandons the partial frame
        if (s1_sop_q && (state_q == StScan)) begin
          frame_err_q <= 1'b1;
        end
        cnt_q <= bin_cur + BIN_W'(1);
        if (s1_sop_q) begin
          best_found_q <= 1'b0;
          best_bin_q   <= '0;
          best_mag_q   <= '0;
`ifdef PEAK_NEIGHBOR_EN
          best_left_q  <= '0;
          best_right_q <= '0;
          right_pend_q <= 1'b0;
`endif
        end
        if (cand) begin
          best_found_q <= 1'b1;
          best_bin_q   <= bin_cur;
          best_mag_q   <= s1_mag_q;
`ifdef PEAK_NEIGHBOR_EN
          best_left_q  <= left_val;
          best_right_q <= '0;
          right_pend_q <= 1'b1;
`endif
        end
`ifdef PEAK_NEIGHBOR_EN
        else if (right_pend_q && !s1_sop_q) begin
          // Captured regardless of the window
          best_right_q <= s1_mag_q;
          right_pend_q <= 1'b0;
        end
        prev_mag_q <= s1_mag_q;
`endif
        if (s1_eop_q) begin
          state_q   <= StReport;
          eop_err_q <= eop_bad;
        end else begin
          state_q   <= StScan;
        end
      end else if (s1_valid_q && s1_eop_q) begin
        // eop outside a frame: flag it, no report
        frame_err_q <= 1'b1;
      end
    end
  end

  assign peak_valid = peak_valid_q;
  assign peak_found = peak_found_q;
  assign peak_bin   = peak_bin_q;
  assign peak_mag   = peak_mag_q;
  assign frame_err  = frame_err_q;

`ifdef PEAK_NEIGHBOR_EN
  assign mag_left   = mag_left_q;
  assign mag_right  = mag_right_q;
`else
  // Neighbour magnitudes are not tracked in this build
`endif

endmodule
